seg7_scroll_mux: RTL and testbench

SEG7_SCROLL_MUX -- requirements
Module: seg7_scroll_mux

---
 rtl/seg7_scroll_mux.sv | 202 ++++++++++++++++++++
 tb/tb_seg7_scroll_mux.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scroll_mux.sv
// rtl/seg7_scroll_mux.sv - multiplexed seven-segment message display with static, scroll, blink and blank modes
module seg7_scroll_mux #(
    parameter int NDIGITS     = 4,
    parameter int DEPTH       = 16,
    parameter int REFRESH_DIV = 1000,
    parameter int SCROLL_DIV  = 500000
) (
    input  logic                       clk_2,
    input  logic                       reset_n,
    input  logic                       wr_valid,
    input  logic [5:0]                 wr_code,
    output logic                       wr_ready,
    input  logic                       clear,
    input  logic [1:0]                 mode,
    output logic [7:0]                 SEG,
    output logic [NDIGITS-1:0]         AN,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int SW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
    localparam int DW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    // Wide enough for offset + digit, which stays below twice the longest virtual length.
    localparam int VW = $clog2(2 * (DEPTH + NDIGITS));

    typedef enum logic [1:0] {
        MODE_STATIC = 2'd0,
        MODE_SCROLL = 2'd1,
        MODE_BLINK  = 2'd2,
        MODE_BLANK  = 2'd3
    } mode_t;

    logic [5:0]         msg_buf [DEPTH];
    logic [RW-1:0]      ref_cnt;
    logic [DW-1:0]      digit;
    logic [SW-1:0]      step_cnt;
    logic [1:0]         mode_q;
    logic               blink_on;
    logic [VW-1:0]      offset;

    logic               wr_fire;
    logic               ref_wrap;
    logic               step_pulse;
    logic               mode_chg;
    mode_t              mode_sel;
    logic [VW-1:0]      virt_len;
    logic [VW-1:0]      pos_sum;
    logic [VW-1:0]      virt_idx;
    logic               static_on;
    logic               scroll_on;
    logic [6:0]         static_glyph;
    logic [6:0]         scroll_glyph;
    logic [NDIGITS-1:0] an_onehot;
    logic [7:0]         seg_d;
    logic [NDIGITS-1:0] an_d;

    function automatic logic [6:0] decode(input logic [5:0] code);
        logic [6:0] g;
        case (code)
            6'd0:    g = 7'h3F;  6'd1:  g = 7'h06;  6'd2:  g = 7'h5B;  6'd3:  g = 7'h4F;
            6'd4:    g = 7'h66;  6'd5:  g = 7'h6D;  6'd6:  g = 7'h7D;  6'd7:  g = 7'h07;
            6'd8:    g = 7'h7F;  6'd9:  g = 7'h6F;  6'd10: g = 7'h77;  6'd11: g = 7'h7C;
            6'd12:   g = 7'h39;  6'd13: g = 7'h5E;  6'd14: g = 7'h79;  6'd15: g = 7'h71;
            6'd16:   g = 7'h77;  6'd17: g = 7'h7C;  6'd18: g = 7'h39;  6'd19: g = 7'h58;
            6'd20:   g = 7'h5E;  6'd21: g = 7'h79;  6'd22: g = 7'h71;  6'd23: g = 7'h6F;
            6'd24:   g = 7'h76;  6'd25: g = 7'h74;  6'd26: g = 7'h06;  6'd27: g = 7'h04;
            6'd28:   g = 7'h1E;  6'd29: g = 7'h38;  6'd30: g = 7'h54;  6'd31: g = 7'h3F;
            6'd32:   g = 7'h5C;  6'd33: g = 7'h73;  6'd34: g = 7'h67;  6'd35: g = 7'h50;
            6'd36:   g = 7'h6D;  6'd37: g = 7'h78;  6'd38: g = 7'h3E;  6'd39: g = 7'h1C;
            6'd40:   g = 7'h6E;  6'd41: g = 7'h63;
            default: g = 7'h40;
        endcase
        return g;
    endfunction

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign wr_ready = !full;
    assign wr_fire  = wr_valid && wr_ready;

    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (wr_fire) begin
            count <= count + 1'b1;
        end
    end

    // Message storage carries no reset; count alone defines which entries are valid.
    always_ff @(posedge clk_2) begin
        if (wr_fire && !clear) begin
            msg_buf[AW'(count)] <= wr_code;
        end
    end

    assign ref_wrap = (ref_cnt == RW'(REFRESH_DIV - 1));

    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            ref_cnt <= '0;
            digit   <= '0;
        end else if (ref_wrap) begin
            ref_cnt <= '0;
            digit   <= (digit == DW'(NDIGITS - 1)) ? '0 : digit + 1'b1;
        end else begin
            ref_cnt <= ref_cnt + 1'b1;
        end
    end

    assign mode_chg   = (mode != mode_q);
    assign step_pulse = (step_cnt == SW'(SCROLL_DIV - 1));

    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            step_cnt <= '0;
            mode_q   <= MODE_STATIC;
            blink_on <= 1'b1;
        end else begin
            mode_q <= mode;
            if (mode_chg) begin
                step_cnt <= '0;
                blink_on <= 1'b1;
            end else if (step_pulse) begin
                step_cnt <= '0;
                blink_on <= !blink_on;
            end else begin
                step_cnt <= step_cnt + 1'b1;
            end
        end
    end

    // The message is followed by NDIGITS blank slots so it scrolls fully off before repeating.
    assign virt_len = VW'(count) + VW'(NDIGITS);

    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            offset <= '0;
        end else if (clear || mode_chg || empty) begin
            offset <= '0;
        end else if (step_pulse) begin
            offset <= (offset >= virt_len - 1'b1) ? '0 : offset + 1'b1;
        end
    end

    assign mode_sel     = mode_t'(mode);
    assign pos_sum      = offset + VW'(digit);
    assign virt_idx     = (pos_sum >= virt_len) ? pos_sum - virt_len : pos_sum;
    assign static_on    = (VW'(digit) < VW'(count));
    assign scroll_on    = (virt_idx < VW'(count));
    assign static_glyph = decode(msg_buf[AW'(digit)]);
    assign scroll_glyph = decode(msg_buf[AW'(virt_idx)]);

    always_comb begin
        an_onehot        = '0;
        an_onehot[digit] = 1'b1;
    end

    always_comb begin
        seg_d = '0;
        an_d  = '0;
        case (mode_sel)
            MODE_STATIC: begin
                an_d = an_onehot;
                if (static_on) seg_d[6:0] = static_glyph;
            end
            MODE_SCROLL: begin
                an_d = an_onehot;
                if (scroll_on) begin
                    seg_d[6:0] = scroll_glyph;
                    seg_d[7]   = (virt_idx == '0);
                end
            end
            MODE_BLINK: begin
                if (blink_on) begin
                    an_d = an_onehot;
                    if (static_on) seg_d[6:0] = static_glyph;
                end
            end
            default: begin
                seg_d = '0;
                an_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            SEG <= '0;
            AN  <= '0;
        end else begin
            SEG <= seg_d;
            AN  <= an_d;
        end
    end

endmodule

// File: tb/tb_seg7_scroll_mux.sv
// tb/tb_seg7_scroll_mux.sv - table-driven scoreboard bench for seg7_scroll_mux
module tb_seg7_scroll_mux;

    localparam int NDIGITS     = 4;
    localparam int DEPTH       = 8;
    localparam int REFRESH_DIV = 2;
    localparam int SCROLL_DIV  = 16;

    logic       clk_2    = 1'b0;
    logic       reset_n  = 1'b0;
    logic       wr_valid = 1'b0;
    logic [5:0] wr_code  = '0;
    logic       clear    = 1'b0;
    logic [1:0] mode     = 2'd0;
    logic       wr_ready;
    logic [7:0] SEG;
    logic [3:0] AN;
    logic [3:0] count;
    logic       full;
    logic       empty;

    seg7_scroll_mux #(
        .NDIGITS(NDIGITS),
        .DEPTH(DEPTH),
        .REFRESH_DIV(REFRESH_DIV),
        .SCROLL_DIV(SCROLL_DIV)
    ) dut (
        .clk_2(clk_2),
        .reset_n(reset_n),
        .wr_valid(wr_valid),
        .wr_code(wr_code),
        .wr_ready(wr_ready),
        .clear(clear),
        .mode(mode),
        .SEG(SEG),
        .AN(AN),
        .count(count),
        .full(full),
        .empty(empty)
    );

    always #5 clk_2 = ~clk_2;

    typedef struct packed {
        logic [5:0] code;
        logic [7:0] seg;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] exp_q[$];
    string       name_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;

    task automatic step();
        @(posedge clk_2);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int target);
        while (cyc < target) step();
    endtask

    task automatic expect_val(input string name, input logic [31:0] value);
        exp_q.push_back(value);
        name_q.push_back(name);
    endtask

    task automatic check_next(input logic [31:0] actual);
        logic [31:0] e;
        string       n;
        e = exp_q.pop_front();
        n = name_q.pop_front();
        checks++;
        if (actual !== e) begin
            errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h", n, actual, e);
        end
    endtask

    task automatic wait_an(input logic [3:0] want, input int budget);
        int n = 0;
        while (AN !== want && n < budget) begin
            step();
            n++;
        end
        if (AN !== want) begin
            checks++;
            errors++;
            $display("FAIL wait_an: AN 0x%0h never reached 0x%0h", AN, want);
        end
    endtask

    task automatic write_code(input logic [5:0] c);
        wr_valid = 1'b1;
        wr_code  = c;
        step();
        wr_valid = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0]  seq_seg [4];
        logic [3:0]  an_exp;
        int          base;
        logic        on;

        vecs.push_back({6'd0,  8'h3F});
        vecs.push_back({6'd2,  8'h5B});
        vecs.push_back({6'd7,  8'h07});
        vecs.push_back({6'd10, 8'h77});
        vecs.push_back({6'd15, 8'h71});
        vecs.push_back({6'd16, 8'h77});
        vecs.push_back({6'd19, 8'h58});
        vecs.push_back({6'd24, 8'h76});
        vecs.push_back({6'd26, 8'h06});
        vecs.push_back({6'd31, 8'h3F});
        vecs.push_back({6'd33, 8'h73});
        vecs.push_back({6'd41, 8'h63});
        vecs.push_back({6'd42, 8'h40});
        vecs.push_back({6'd63, 8'h40});
        seq_seg[0] = 8'h06;
        seq_seg[1] = 8'h5B;
        seq_seg[2] = 8'h4F;
        seq_seg[3] = 8'h00;

        // Reset state
        #12;
        expect_val("rst_seg", 0);      check_next(32'(SEG));
        expect_val("rst_an", 0);       check_next(32'(AN));
        expect_val("rst_count", 0);    check_next(32'(count));
        expect_val("rst_empty", 1);    check_next(32'(empty));
        expect_val("rst_full", 0);     check_next(32'(full));
        expect_val("rst_wr_ready", 1); check_next(32'(wr_ready));

        @(negedge clk_2);
        reset_n = 1'b1;
        #1;
        expect_val("an_before_edge", 0); check_next(32'(AN));
        step();
        expect_val("an_first_edge", 1);  check_next(32'(AN));

        // Static display sequence with three characters
        write_code(6'd1);
        write_code(6'd2);
        write_code(6'd3);
        wait_an(4'b0010, 10);
        wait_an(4'b0001, 10);
        for (int i = 0; i < 8; i++) begin
            an_exp = 4'b0001 << (i / 2);
            expect_val("seq_an", 32'(an_exp));
            expect_val("seq_seg", 32'(seq_seg[i / 2]));
            check_next(32'(AN));
            check_next(32'(SEG));
            step();
        end

        // Decoder table
        foreach (vecs[i]) begin
            do_clear();
            write_code(vecs[i].code);
            step();
            expect_val($sformatf("decode_%0d", vecs[i].code), 32'(vecs[i].seg));
            wait_an(4'b0001, 10);
            check_next(32'(SEG));
        end

        // Clear wins over a same-cycle write
        do_clear();
        write_code(6'd1);
        write_code(6'd2);
        write_code(6'd3);
        expect_val("pre_clear_count", 3); check_next(32'(count));
        clear    = 1'b1;
        wr_valid = 1'b1;
        wr_code  = 6'd5;
        step();
        clear    = 1'b0;
        wr_valid = 1'b0;
        expect_val("clr_count", 0); check_next(32'(count));
        expect_val("clr_empty", 1); check_next(32'(empty));
        step();
        expect_val("clr_no_write", 0);
        wait_an(4'b0001, 10);
        check_next(32'(SEG));

        // Fill to full, then an ignored ninth write
        do_clear();
        for (int i = 0; i < 8; i++) begin
            write_code(6'(10 + i));
            if (i == 6) begin
                expect_val("count_7", 7); check_next(32'(count));
                expect_val("full_7", 0);  check_next(32'(full));
            end
        end
        expect_val("full_8", 1);     check_next(32'(full));
        expect_val("wr_ready_8", 0); check_next(32'(wr_ready));
        expect_val("count_8", 8);    check_next(32'(count));
        expect_val("empty_8", 0);    check_next(32'(empty));
        write_code(6'd33);
        expect_val("count_9th", 8);  check_next(32'(count));
        mode = 2'd1;
        base = cyc;
        run_to(base + 68);
        expect_val("buf7_kept", 32'h7C);
        wait_an(4'b1000, 10);
        check_next(32'(SEG));

        // Scroll of "HI": L = 6
        mode = 2'd0;
        step();
        do_clear();
        write_code(6'd24);
        write_code(6'd26);
        mode = 2'd1;
        base = cyc;
        step();
        expect_val("scr_off0_pos0", 32'hF6);
        wait_an(4'b0001, 8);
        check_next(32'(SEG));
        expect_val("scr_off0_pos1", 32'h06);
        wait_an(4'b0010, 4);
        check_next(32'(SEG));
        run_to(base + 20);
        expect_val("scr_off1_pos0", 32'h06);
        wait_an(4'b0001, 8);
        check_next(32'(SEG));
        run_to(base + 84);
        expect_val("scr_off5_pos0", 32'h00);
        wait_an(4'b0001, 8);
        check_next(32'(SEG));
        run_to(base + 100);
        expect_val("scr_wrap_pos0", 32'hF6);
        wait_an(4'b0001, 8);
        check_next(32'(SEG));

        // Blink phases, then switch to static during an off phase
        mode = 2'd0;
        step();
        do_clear();
        write_code(6'd8);
        mode = 2'd2;
        base = cyc;
        run_to(base + 1);
        for (int k = 2; k < 50; k++) begin
            step();
            on = (k <= 17) || (k >= 34);
            expect_val($sformatf("blink_an_on_%0d", k), 32'(on));
            check_next(32'(AN != 4'b0000));
            if (!on) begin
                expect_val($sformatf("blink_seg_off_%0d", k), 0);
                check_next(32'(SEG));
            end
        end
        run_to(base + 55);
        expect_val("blink_off_mid", 0); check_next(32'(AN));
        mode = 2'd0;
        step();
        expect_val("blink_to_static", 1); check_next(32'(AN != 4'b0000));

        // Asynchronous reset while scrolling
        mode = 2'd1;
        step();
        step();
        expect_val("scroll_an_live", 1); check_next(32'(AN != 4'b0000));
        #3;
        reset_n = 1'b0;
        #1;
        expect_val("async_seg", 0);   check_next(32'(SEG));
        expect_val("async_an", 0);    check_next(32'(AN));
        expect_val("async_count", 0); check_next(32'(count));
        expect_val("async_empty", 1); check_next(32'(empty));
        @(negedge clk_2);
        reset_n = 1'b1;
        step();
        expect_val("rerelease_an", 1); check_next(32'(AN));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
